vip_axi4_burst_splitter: RTL and testbench

Converts one linear transfer command (start address, beat count, ID) into a legal sequence of AXI4 INCR address-channel requests (AW or AR). Each request is at most 256 beats and never crosses a 4 KB boundary. Sits directly upstream of an AXI4 master address channel, feeding request fields in the encodings defined by `vip_axi4_types_pkg` (burst, size, max burst length 256, 4 KB boundary).

---
 rtl/vip_axi4_burst_splitter.sv | 125 ++++++++++++
 tb/tb_vip_axi4_burst_splitter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vip_axi4_burst_splitter.sv
// Splits one linear transfer command into AXI4 INCR address requests of at
// most 256 beats each, none of which crosses a 4 KB boundary.
module vip_axi4_burst_splitter #(
  parameter int unsigned ID_WIDTH_P    = 4,
  parameter int unsigned ADDR_WIDTH_P  = 32,
  parameter int unsigned DATA_WIDTH_P  = 64,
  parameter int unsigned BEATS_WIDTH_P = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ID_WIDTH_P-1:0]    cmd_id,
  input  logic [ADDR_WIDTH_P-1:0]  cmd_addr,
  input  logic [BEATS_WIDTH_P-1:0] cmd_beats,
  output logic                     ax_valid,
  input  logic                     ax_ready,
  output logic [ID_WIDTH_P-1:0]    ax_id,
  output logic [ADDR_WIDTH_P-1:0]  ax_addr,
  output logic [7:0]               ax_len,
  output logic [2:0]               ax_size,
  output logic [1:0]               ax_burst,
  output logic                     ax_last,
  output logic                     busy
);

  localparam int unsigned BYTES_C = DATA_WIDTH_P / 8;
  localparam int unsigned SH_C    = $clog2(BYTES_C);
  // Common compare width wide enough for both the beat counter and to4k.
  localparam int unsigned CW_C    = (BEATS_WIDTH_P > 13) ? BEATS_WIDTH_P : 13;

  typedef enum logic [1:0] {IDLE_S, CALC_S, ISSUE_S} state_e;

  state_e                   state_q;
  logic [ADDR_WIDTH_P-1:0]  addr_q;
  logic [BEATS_WIDTH_P-1:0] rem_q;
  logic [ID_WIDTH_P-1:0]    id_q;
  logic [7:0]               len_q;
  logic                     valid_q;
  logic                     last_q;
  logic                     ready_q;
  logic                     busy_q;

  logic [12:0]              to4k_d;
  logic [CW_C-1:0]          n_w;
  logic [8:0]               n_d;
  logic                     last_d;
  logic [8:0]               n_iss;
  logic [ADDR_WIDTH_P-1:0]  step_bytes;

  // Size of the next request and the address/counter step of the issued one.
  always_comb begin
    to4k_d = (13'd4096 - {1'b0, addr_q[11:0]}) >> SH_C;
    n_w    = CW_C'(rem_q);
    if (n_w > CW_C'(256))
      n_w = CW_C'(256);
    if (n_w > CW_C'(to4k_d))
      n_w = CW_C'(to4k_d);
    n_d        = 9'(n_w);
    last_d     = (CW_C'(rem_q) == n_w);
    n_iss      = {1'b0, len_q} + 9'd1;
    step_bytes = ADDR_WIDTH_P'(n_iss) << SH_C;
  end

  // Command/request FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE_S;
      addr_q  <= '0;
      rem_q   <= '0;
      id_q    <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE_S: begin
          ready_q <= 1'b1;
          if (cmd_valid && ready_q && (cmd_beats != '0)) begin
            id_q    <= cmd_id;
            addr_q  <= cmd_addr & ~ADDR_WIDTH_P'(BYTES_C - 1);
            rem_q   <= cmd_beats;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CALC_S;
          end
        end
        CALC_S: begin
          len_q   <= 8'(n_d - 9'd1);
          last_q  <= last_d;
          valid_q <= 1'b1;
          state_q <= ISSUE_S;
        end
        ISSUE_S: begin
          if (ax_ready) begin
            valid_q <= 1'b0;
            addr_q  <= addr_q + step_bytes;
            rem_q   <= rem_q - BEATS_WIDTH_P'(n_iss);
            if (last_q) begin
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
              state_q <= IDLE_S;
            end else begin
              state_q <= CALC_S;
            end
          end
        end
        default: state_q <= IDLE_S;
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign ax_valid  = valid_q;
  assign ax_id     = id_q;
  assign ax_addr   = addr_q;
  assign ax_len    = len_q;
  assign ax_size   = 3'(SH_C);
  assign ax_burst  = 2'b01;
  assign ax_last   = last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_vip_axi4_burst_splitter.sv
// Bench for vip_axi4_burst_splitter: directed table, hand sequences for
// reset/latency corners, and random commands against an arithmetic model.
module tb_vip_axi4_burst_splitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_id = '0;
  logic [31:0] cmd_addr = '0;
  logic [15:0] cmd_beats = '0;
  logic        ax_valid;
  logic        ax_ready = 1'b0;
  logic [3:0]  ax_id;
  logic [31:0] ax_addr;
  logic [7:0]  ax_len;
  logic [2:0]  ax_size;
  logic [1:0]  ax_burst;
  logic        ax_last;
  logic        busy;

  vip_axi4_burst_splitter #(
    .ID_WIDTH_P(4), .ADDR_WIDTH_P(32), .DATA_WIDTH_P(64), .BEATS_WIDTH_P(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
    .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .ax_valid(ax_valid), .ax_ready(ax_ready), .ax_id(ax_id), .ax_addr(ax_addr),
    .ax_len(ax_len), .ax_size(ax_size), .ax_burst(ax_burst), .ax_last(ax_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic        last;
  } req_t;

  typedef struct {
    logic [3:0]        id;
    logic [31:0]       addr;
    int unsigned       beats;
    int unsigned       mode;
    int unsigned       stalls;
    int unsigned       nreq;
    logic [2:0][31:0]  ea;
    logic [2:0][7:0]   el;
  } vec_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  req_t        got_q[$];
  req_t        exp_q[$];
  int unsigned ready_mode = 0;
  int unsigned stall_left = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_snap = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs at a falling edge: choose ax_ready for the coming rising edge,
  // record a handshake that edge will perform, then advance one cycle.
  task automatic step();
    logic [63:0] snap;
    req_t r;
    case (ready_mode)
      0:       ax_ready = 1'b1;
      1:       ax_ready = ($urandom_range(0, 99) < 60);
      default: begin
        if (ax_valid && stall_left > 0) begin
          ax_ready = 1'b0;
          stall_left--;
        end else begin
          ax_ready = 1'b1;
        end
      end
    endcase
    snap = {13'b0, ax_valid, ax_id, ax_addr, ax_len, ax_last, ax_size, ax_burst};
    if (prev_stall) check("stall_hold", snap, prev_snap);
    if (ax_valid && ax_ready) begin
      r.id = ax_id; r.addr = ax_addr; r.len = ax_len; r.last = ax_last;
      got_q.push_back(r);
      check("ax_size", ax_size, 3'd3);
      check("ax_burst", ax_burst, 2'b01);
    end
    prev_stall = ax_valid && !ax_ready;
    prev_snap  = snap;
    @(negedge clk);
  endtask

  // Reference: split a command by the 256-beat and 4 KB rules.
  function automatic void model(input logic [3:0] id, input logic [31:0] addr,
                                input int unsigned beats);
    logic [31:0] a;
    int unsigned rem, room, n;
    req_t r;
    exp_q.delete();
    a   = addr & 32'hFFFF_FFF8;
    rem = beats;
    while (rem > 0) begin
      room = (4096 - (a % 4096)) / 8;
      n = rem;
      if (n > 256) n = 256;
      if (n > room) n = room;
      r.id = id; r.addr = a; r.len = 8'(n - 1); r.last = (rem == n);
      exp_q.push_back(r);
      a = a + 32'(n * 8);
      rem -= n;
    end
  endfunction

  task automatic run_cmd(input logic [3:0] id, input logic [31:0] addr,
                         input int unsigned beats, input int unsigned mode,
                         input int unsigned stalls);
    logic finished;
    got_q.delete();
    ready_mode = mode;
    stall_left = stalls;
    prev_stall = 1'b0;
    for (int i = 0; i < 50 && !cmd_ready; i++) step();
    check("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_id = id; cmd_addr = addr; cmd_beats = 16'(beats);
    step();
    cmd_valid = 1'b0;
    if (beats == 0) begin
      check("zero_cmd_ready", cmd_ready, 1'b1);
      check("zero_busy", busy, 1'b0);
      for (int i = 0; i < 4; i++) begin
        step();
        check("zero_busy_hold", busy, 1'b0);
      end
    end else begin
      check("calc_valid_low", ax_valid, 1'b0);
      check("busy_after_accept", busy, 1'b1);
      check("ready_low_busy", cmd_ready, 1'b0);
      step();
      check("first_valid", ax_valid, 1'b1);
      finished = 1'b0;
      for (int c = 0; c < 3000 && !finished; c++) begin
        step();
        finished = (got_q.size() > 0) && got_q[got_q.size()-1].last;
      end
      check("done", finished, 1'b1);
      check("end_busy", busy, 1'b0);
      check("end_valid", ax_valid, 1'b0);
      check("end_ready", cmd_ready, 1'b1);
    end
    check("req_count", got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      check("req_id", got_q[k].id, exp_q[k].id);
      check("req_addr", got_q[k].addr, exp_q[k].addr);
      check("req_len", got_q[k].len, exp_q[k].len);
      check("req_last", got_q[k].last, exp_q[k].last);
    end
  endtask

  function automatic vec_t mkvec(input logic [3:0] id, input logic [31:0] addr,
                                 input int unsigned beats, input int unsigned mode,
                                 input int unsigned stalls, input int unsigned nreq,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] a2, input logic [7:0] l0,
                                 input logic [7:0] l1, input logic [7:0] l2);
    vec_t v;
    v.id = id; v.addr = addr; v.beats = beats; v.mode = mode; v.stalls = stalls;
    v.nreq = nreq;
    v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2;
    v.el[0] = l0; v.el[1] = l1; v.el[2] = l2;
    return v;
  endfunction

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    req_t r;
    logic [31:0] rnd;
    logic [31:0] addr;
    int unsigned beats;

    vecs[0] = mkvec(4'h3, 32'h0000_0000, 16,  0, 0, 1, 32'h0,         32'h0,     32'h0,     8'd15,  8'd0,   8'd0);
    vecs[1] = mkvec(4'h5, 32'h0000_0000, 600, 1, 0, 3, 32'h0,         32'h800,   32'h1000,  8'd255, 8'd255, 8'd87);
    vecs[2] = mkvec(4'h1, 32'h0000_0FF0, 10,  1, 0, 2, 32'hFF0,       32'h1000,  32'h0,     8'd1,   8'd7,   8'd0);
    vecs[3] = mkvec(4'h9, 32'h0000_0FF5, 2,   2, 5, 1, 32'hFF0,       32'h0,     32'h0,     8'd1,   8'd0,   8'd0);
    vecs[4] = mkvec(4'h2, 32'h0000_1234, 0,   0, 0, 0, 32'h0,         32'h0,     32'h0,     8'd0,   8'd0,   8'd0);
    vecs[5] = mkvec(4'h7, 32'h0000_0007, 1,   1, 0, 1, 32'h0,         32'h0,     32'h0,     8'd0,   8'd0,   8'd0);
    vecs[6] = mkvec(4'hF, 32'hFFFF_FFF8, 3,   1, 0, 2, 32'hFFFF_FFF8, 32'h0,     32'h0,     8'd0,   8'd1,   8'd0);

    // Reset state, then release.
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_ax_valid", ax_valid, 1'b0);
    check("rst_ax_last", ax_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ax_addr", ax_addr, 32'h0);
    check("rst_ax_len", ax_len, 8'h0);
    check("rst_ax_id", ax_id, 4'h0);
    rst = 1'b0;
    step();
    check("ready_after_rst", cmd_ready, 1'b1);

    // Directed table.
    foreach (vecs[i]) begin
      exp_q.delete();
      for (int k = 0; k < vecs[i].nreq; k++) begin
        r.id = vecs[i].id; r.addr = vecs[i].ea[k]; r.len = vecs[i].el[k];
        r.last = (k == vecs[i].nreq - 1);
        exp_q.push_back(r);
      end
      run_cmd(vecs[i].id, vecs[i].addr, vecs[i].beats, vecs[i].mode, vecs[i].stalls);
    end

    // Reset right after the first handshake of a multi-request command.
    got_q.delete(); ready_mode = 0; prev_stall = 1'b0;
    cmd_valid = 1'b1; cmd_id = 4'h6; cmd_addr = 32'h0; cmd_beats = 16'd600;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && got_q.size() == 0; i++) step();
    check("mid_first_hs", got_q.size(), 1);
    rst = 1'b1;
    step();
    check("mid_rst_valid", ax_valid, 1'b0);
    check("mid_rst_ready", cmd_ready, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_addr", ax_addr, 32'h0);
    check("mid_rst_len", ax_len, 8'h0);
    check("mid_rst_id", ax_id, 4'h0);
    rst = 1'b0;
    prev_stall = 1'b0;
    step();
    check("mid_ready_after_rst", cmd_ready, 1'b1);
    for (int i = 0; i < 30; i++) step();
    check("mid_no_more_reqs", got_q.size(), 1);

    // Random commands against the reference model.
    for (int t = 0; t < 40; t++) begin
      rnd = $urandom;
      case ($urandom_range(0, 3))
        0: addr = rnd;
        1: addr = {rnd[31:12], 12'hF00 + 12'($urandom_range(0, 255))};
        2: addr = 32'hFFFF_F000 + 32'($urandom_range(0, 4095));
        default: addr = {rnd[31:12], 12'h000};
      endcase
      case ($urandom_range(0, 7))
        0: beats = 0;
        1, 2: beats = $urandom_range(1, 20);
        default: beats = $urandom_range(1, 1200);
      endcase
      model(rnd[3:0], addr, beats);
      run_cmd(rnd[3:0], addr, beats, 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
